lfsr_encrypt_engine: RTL and testbench
======================================

# lfsr_encrypt_engine

Hardware encryptor for the LFSR message-cipher protocol, the transmit side of the decrypt/depad flow. On Start it reads the configuration and a 52-byte ASCII message from data memory. It space-pads the message to 64 bytes, subtracts 0x20 from each byte, XORs each byte with a 7-bit LFSR sequence, and prepends an even-parity bit. The 64 ciphertext bytes are written to data memory at 64..127, which is the layout the decryptor consumes.

## Interface
- No parameters; sizes fixed in `enc_pkg`.
- Clk  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  level; high holds engine idle, high→low launches a run.
- Ack  out  1  run complete; reset 0.
- rd_addr  out  8  data-memory read address; reset 0.
- rd_data  in  8  data-memory read data, valid one cycle after rd_addr (synchronous read).
- wr_addr  out  8  data-memory write address; reset 0.
- wr_data  out  8  ciphertext byte; reset 0.
- wr_en  out  1  write strobe; reset 0.

## Operation
- FSM states:
  - IDLE: on Start sampled 0 with previous sample 1 → CFG, Ack←0.
  - CFG: 4 cycles. Issue reads of 61 (pre_length[3:0]), 62 (ptrn[6:0]) and 63 (init[6:0]); capture each one cycle later. Then → RUN.
  - RUN: 65 cycles, 2-stage pipeline, one byte per cycle. Byte i (0..63) issues its read in RUN cycle i and writes in RUN cycle i+1. Then → DONE.
  - DONE: Ack=1, held until Start=1, then → IDLE with Ack←0.
- Byte i uses plaintext p = DM[i−pre]−0x20 if pre ≤ i < pre+52, else p = 0x00.
  - Padded bytes issue no meaningful read; rd_addr is don't-care.
  - Message bytes with pre+i ≥ 64 are dropped: output is truncated at 64 bytes.
- LFSR:
  - s0 = init.
  - s(k+1) = {s(k)[5:0], ^(s(k) & ptrn)}.
  - Stepped once per issued byte, including padded bytes.
- Cipher byte: c[6:0] = p[6:0] ^ s(i); c[7] = ^c[6:0]. The write goes to address 64+i.
- Input characters are assumed to be 0x20..0x9F, so p fits 7 bits; p[7] is discarded.
- init=0 is not guarded: the LFSR stays 0 and the ciphertext is the parity-tagged plaintext.
- Start rising during CFG/RUN is ignored; the run completes.

## Timing
- Launch edge E0 is the edge where IDLE samples Start=0 after Start=1.
- CFG occupies E0+1..E0+4.
- First wr_en is at cycle E0+6; the last (address 127) is at E0+69.
- Ack rises at E0+70. Total latency is 70 cycles.
- wr_en is high exactly 64 cycles, contiguous.
- Reset (any state, including mid-RUN): next edge goes to IDLE with Ack, wr_en, rd_addr, wr_addr and wr_data all 0. Memory already written is left as is. Start must go high→low again to launch.
- Start held low through reset: no run, since no high→low transition is seen.

## Configuration
- PRELEN_CLAMP_EN
  - Defined: captured pre_length < 10 is replaced by 10.
  - Undefined: used raw, 0..15.
  - Affects only the padding window.

## Structure
- `enc_pkg`:
  - state enum {IDLE, CFG, RUN, DONE}.
  - Constants: MSG_LEN=52, OUT_LEN=64, OUT_BASE=64, ADDR_PRE=61, ADDR_PTRN=62, ADDR_INIT=63, SPACE=8'h20, PRE_MIN=10.
- Sub-module `lfsr7_step`: combinational next-state from (state, ptrn), reused by the decryptor.

## Test plan
- ptrn=0x60, init=0x01, pre=10, DM[0..51]="Mr. Watson, come here. I want to see you." space-padded → DM[64]=0x81, DM[65]=0x82, DM[70]=0x41, DM[74]=0x35; Ack at E0+70.
- Same stimulus with pre=3:
  - PRELEN_CLAMP_EN defined: output identical to the pre=10 run.
  - Undefined: DM[67]=p('M')^s3 = 0x2D^0x08 = 0x25 → 0xA5.
- pre=15: message byte 49 maps to output byte 64 and is dropped; no write beyond address 127; exactly 64 wr_en cycles.
- Reset asserted at E0+30 for 1 cycle: next cycle wr_en=0, Ack=0, state IDLE; a relaunch produces the full correct output.
- Start held high for 20 cycles after Reset: no reads or writes. Drop Start: run completes. Raise Start after Ack: Ack falls next cycle.
- init=0, pre=10: DM[74]=0x2D with parity → 0x2D (4 ones, parity 0); padded bytes are all 0x00.

Source files
------------

// File: rtl/lfsr_encrypt_engine_pkg.sv
// Shared types and constants for the LFSR message-cipher encryptor.
package enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0] MSG_LEN   = 7'd52;
    localparam logic [6:0] OUT_LEN   = 7'd64;
    localparam logic [7:0] OUT_BASE  = 8'd64;
    localparam logic [7:0] ADDR_PRE  = 8'd61;
    localparam logic [7:0] ADDR_PTRN = 8'd62;
    localparam logic [7:0] ADDR_INIT = 8'd63;
    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [3:0] PRE_MIN   = 4'd10;

    // Ciphertext byte: even-parity bit on top of the 7 data bits.
    function automatic logic [7:0] add_parity(input logic [6:0] c);
        return {^c, c};
    endfunction

endpackage

// File: rtl/lfsr_encrypt_engine_if.sv
// Control handshake plus synchronous data-memory port of the encryptor.
interface lfsr_encrypt_engine_if;
    logic       Start;
    logic       Ack;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_en;

    // Engine side: drives the memory bus and reports completion.
    modport master (
        input  Start, rd_data,
        output Ack, rd_addr, wr_addr, wr_data, wr_en
    );

    // Memory/host side.
    modport slave (
        output Start, rd_data,
        input  Ack, rd_addr, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/lfsr_encrypt_engine_lfsr7_step.sv
// One step of the 7-bit Fibonacci LFSR; shared with the decryptor.
module lfsr7_step (
    input  logic [6:0] state_i,
    input  logic [6:0] ptrn_i,
    output logic [6:0] next_o
);
    // Shift left, feed back the parity of the tapped bits.
    assign next_o = {state_i[5:0], ^(state_i & ptrn_i)};
endmodule

// File: rtl/lfsr_encrypt_engine.sv
// LFSR message encryptor: reads config + 52-byte message, writes 64
// parity-tagged ciphertext bytes to addresses 64..127.
// Optional macro PRELEN_CLAMP_EN: clamp the captured pre-length to >= 10.
module lfsr_encrypt_engine
    import enc_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset,
    lfsr_encrypt_engine_if.master bus
);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       start_prev_q, start_prev_d;
    logic [3:0] pre_q, pre_d;
    logic [6:0] ptrn_q, ptrn_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic       ack_q, ack_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;

    logic [6:0] lfsr_next;
    logic [3:0] pre_eff;
    logic [6:0] byte_idx;
    logic       in_win;
    logic [7:0] p_full;
    logic [6:0] p_byte;
    logic       unused_p_msb;

    lfsr7_step u_step (
        .state_i (lfsr_q),
        .ptrn_i  (ptrn_q),
        .next_o  (lfsr_next)
    );

`ifdef PRELEN_CLAMP_EN
    assign pre_eff = (bus.rd_data[3:0] < PRE_MIN) ? PRE_MIN : bus.rd_data[3:0];
`else
    assign pre_eff = bus.rd_data[3:0];
`endif

    // Byte being written this RUN cycle (its read was issued one cycle earlier).
    assign byte_idx     = cnt_q - 7'd1;
    assign in_win       = ({3'd0, pre_q} <= byte_idx) && (byte_idx < {3'd0, pre_q} + MSG_LEN);
    assign p_full       = bus.rd_data - SPACE;
    assign unused_p_msb = p_full[7];
    assign p_byte       = in_win ? p_full[6:0] : 7'd0;

    // Next-state and output decode; every register holds by default.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_prev_d = bus.Start;
        pre_d        = pre_q;
        ptrn_d       = ptrn_q;
        lfsr_d       = lfsr_q;
        ack_d        = ack_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.Start && start_prev_q) begin
                    state_d   = CFG;
                    cnt_d     = 7'd0;
                    ack_d     = 1'b0;
                    rd_addr_d = ADDR_PRE;
                end
            end
            CFG: begin
                cnt_d = cnt_q + 7'd1;
                case (cnt_q[1:0])
                    2'd0: rd_addr_d = ADDR_PTRN;
                    2'd1: begin
                        rd_addr_d = ADDR_INIT;
                        pre_d     = pre_eff;
                    end
                    2'd2: ptrn_d = bus.rd_data[6:0];
                    default: begin
                        lfsr_d    = bus.rd_data[6:0];
                        rd_addr_d = 8'd0 - {4'd0, pre_q};
                        cnt_d     = 7'd0;
                        state_d   = RUN;
                    end
                endcase
            end
            RUN: begin
                cnt_d     = cnt_q + 7'd1;
                rd_addr_d = {1'b0, cnt_q} + 8'd1 - {4'd0, pre_q};
                if (cnt_q != 7'd0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = OUT_BASE + {1'b0, byte_idx};
                    wr_data_d = add_parity(p_byte ^ lfsr_q);
                    lfsr_d    = lfsr_next;
                end
                if (cnt_q == OUT_LEN) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack_d = 1'b1;
                if (bus.Start && ack_q) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 7'd0;
            start_prev_q <= 1'b0;
            pre_q        <= 4'd0;
            ptrn_q       <= 7'd0;
            lfsr_q       <= 7'd0;
            ack_q        <= 1'b0;
            rd_addr_q    <= 8'd0;
            wr_addr_q    <= 8'd0;
            wr_data_q    <= 8'd0;
            wr_en_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_prev_d;
            pre_q        <= pre_d;
            ptrn_q       <= ptrn_d;
            lfsr_q       <= lfsr_d;
            ack_q        <= ack_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
        end
    end

    assign bus.Ack     = ack_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.wr_en   = wr_en_q;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Directed bench for lfsr_encrypt_engine: vector table plus corner sequences.
module tb_lfsr_encrypt_engine;

    logic Clk = 1'b0;
    logic Reset;
    logic clear_out = 1'b0;

    lfsr_encrypt_engine_if bus();

    lfsr_encrypt_engine dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Data memory: 0..63 loaded by the bench, 64..255 written by the DUT.
    logic [7:0] in_mem  [0:63];
    logic [7:0] out_mem [0:255];

    always @(posedge Clk) begin
        bus.rd_data <= (bus.rd_addr < 8'd64) ? in_mem[bus.rd_addr[5:0]] : out_mem[bus.rd_addr];
        if (clear_out) begin
            for (int a = 0; a < 256; a++) out_mem[a] <= 8'hEE;
        end else if (bus.wr_en) begin
            out_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    int checks   = 0;
    int failures = 0;

    string MSG = "Mr. Watson, come here. I want to see you.";

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int idx);
        if (idx < MSG.len()) return MSG[idx];
        return 8'h20;
    endfunction

    function automatic int pre_eff(input logic [3:0] pre);
`ifdef PRELEN_CLAMP_EN
        return (pre < 4'd10) ? 10 : int'(pre);
`else
        return int'(pre);
`endif
    endfunction

    // Reference cipher byte i, straight from the protocol description.
    function automatic logic [7:0] model(input int pe, input logic [6:0] ptrn,
                                         input logic [6:0] init, input int i);
        logic [6:0] s;
        logic [6:0] p;
        logic [6:0] c;
        logic [7:0] d;
        s = init;
        for (int k = 0; k < i; k++) s = {s[5:0], ^(s & ptrn)};
        p = 7'd0;
        if (i >= pe && i < pe + 52) begin
            d = msg_byte(i - pe) - 8'h20;
            p = d[6:0];
        end
        c = p ^ s;
        return {^c, c};
    endfunction

    task automatic load(input logic [3:0] pre, input logic [6:0] ptrn, input logic [6:0] init);
        for (int i = 0; i < 64; i++) in_mem[i] = 8'h00;
        for (int i = 0; i < 52; i++) in_mem[i] = msg_byte(i);
        in_mem[61] = {4'h0, pre};
        in_mem[62] = {1'b0, ptrn};
        in_mem[63] = {1'b0, init};
        @(negedge Clk) clear_out = 1'b1;
        @(negedge Clk) clear_out = 1'b0;
    endtask

    // Returns just after the launch edge E0.
    task automatic launch();
        @(negedge Clk) bus.Start = 1'b1;
        @(negedge Clk);
        @(negedge Clk) bus.Start = 1'b0;
        @(posedge Clk);
    endtask

    task automatic run_once(input logic [3:0] pre, input logic [6:0] ptrn,
                            input logic [6:0] init, input string tag);
        int first_wr, ack_at, wr_cnt, bad_order, bad_bytes, over;
        first_wr = -1; ack_at = -1; wr_cnt = 0; bad_order = 0;
        load(pre, ptrn, init);
        launch();
        for (int n = 1; n <= 150 && ack_at < 0; n++) begin
            @(posedge Clk);
            #1;
            if (bus.wr_en) begin
                if (first_wr < 0) first_wr = n;
                if (bus.wr_addr != 8'(64 + wr_cnt)) bad_order++;
                wr_cnt++;
            end
            if (bus.Ack && ack_at < 0) ack_at = n;
        end
        bad_bytes = 0;
        for (int i = 0; i < 64; i++)
            if (out_mem[64 + i] !== model(pre_eff(pre), ptrn, init, i)) bad_bytes++;
        over = 0;
        for (int a = 128; a < 256; a++)
            if (out_mem[a] !== 8'hEE) over++;
        check({tag, " first_wr_cycle"}, first_wr, 6);
        check({tag, " ack_cycle"}, ack_at, 70);
        check({tag, " wr_en_cycles"}, wr_cnt, 64);
        check({tag, " wr_addr_order_errs"}, bad_order, 0);
        check({tag, " model_byte_errs"}, bad_bytes, 0);
        check({tag, " writes_past_127"}, over, 0);
        @(negedge Clk);
        check({tag, " ack_held"}, int'(bus.Ack), 1);
        bus.Start = 1'b1;
        @(posedge Clk);
        #1;
        check({tag, " ack_falls"}, int'(bus.Ack), 0);
    endtask

    typedef struct {
        logic [3:0] pre;
        logic [6:0] ptrn;
        logic [6:0] init;
        logic [7:0] addr;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int busy;
`ifdef PRELEN_CLAMP_EN
        logic [7:0] exp_pre3 = 8'h88;
        logic [7:0] exp_pre0 = 8'h81;
`else
        logic [7:0] exp_pre3 = 8'hA5;
        logic [7:0] exp_pre0 = 8'hAC;
`endif
        vecs[0] = '{4'd10, 7'h60, 7'h01, 8'd64,  8'h81,    "pre10 dm64"};
        vecs[1] = '{4'd10, 7'h60, 7'h01, 8'd65,  8'h82,    "pre10 dm65"};
        vecs[2] = '{4'd10, 7'h60, 7'h01, 8'd70,  8'h41,    "pre10 dm70"};
        vecs[3] = '{4'd10, 7'h60, 7'h01, 8'd74,  8'h35,    "pre10 dm74"};
        vecs[4] = '{4'd3,  7'h60, 7'h01, 8'd67,  exp_pre3, "pre3 dm67"};
        vecs[5] = '{4'd0,  7'h60, 7'h01, 8'd64,  exp_pre0, "pre0 dm64"};
        vecs[6] = '{4'd10, 7'h60, 7'h00, 8'd74,  8'h2D,    "init0 dm74"};
        vecs[7] = '{4'd10, 7'h60, 7'h00, 8'd64,  8'h00,    "init0 dm64"};
        vecs[8] = '{4'd15, 7'h60, 7'h01, 8'd79,  8'h27,    "pre15 dm79"};

        // Reset with Start low: outputs cleared, and no launch afterwards.
        bus.Start = 1'b0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset Ack", int'(bus.Ack), 0);
        check("reset wr_en", int'(bus.wr_en), 0);
        check("reset rd_addr", int'(bus.rd_addr), 0);
        check("reset wr_addr", int'(bus.wr_addr), 0);
        check("reset wr_data", int'(bus.wr_data), 0);
        @(negedge Clk) Reset = 1'b0;
        busy = 0;
        repeat (10) begin
            @(posedge Clk); #1;
            if (bus.wr_en || bus.rd_addr != 8'd0 || bus.Ack) busy++;
        end
        check("start_low_no_run", busy, 0);

        // Start held high for 20 cycles after reset: engine stays idle.
        @(negedge Clk) begin bus.Start = 1'b1; Reset = 1'b1; end
        @(negedge Clk) Reset = 1'b0;
        busy = 0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (bus.wr_en || bus.rd_addr != 8'd0 || bus.Ack) busy++;
        end
        check("start_high_idle", busy, 0);

        // Directed vectors: full run each, plus one hand-computed byte.
        for (int v = 0; v < 9; v++) begin
            run_once(vecs[v].pre, vecs[v].ptrn, vecs[v].init, vecs[v].name);
            check({vecs[v].name, " byte"}, int'(out_mem[vecs[v].addr]), int'(vecs[v].exp));
        end

        // Reset at E0+30, then relaunch.
        load(4'd10, 7'h60, 7'h01);
        launch();
        for (int n = 1; n < 30; n++) @(posedge Clk);
        @(negedge Clk);
        check("midrun wr_en_active", int'(bus.wr_en), 1);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("midrun reset wr_en", int'(bus.wr_en), 0);
        check("midrun reset Ack", int'(bus.Ack), 0);
        check("midrun reset wr_addr", int'(bus.wr_addr), 0);
        check("midrun reset wr_data", int'(bus.wr_data), 0);
        check("midrun reset rd_addr", int'(bus.rd_addr), 0);
        @(negedge Clk) Reset = 1'b0;
        busy = 0;
        repeat (5) begin
            @(posedge Clk); #1;
            if (bus.wr_en || bus.Ack) busy++;
        end
        check("midrun reset idle", busy, 0);
        run_once(4'd10, 7'h60, 7'h01, "relaunch");
        check("relaunch dm74", int'(out_mem[74]), 8'h35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
